// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer logic.
// Contents:
//   FIFO_P_SIZE / FIFO_A_SIZE : default pointer width and address width
//   FIFO_MAX_W                : widest pointer the Gray helpers support
//   bin2gray / gray2bin       : code conversions at FIFO_MAX_W bits; callers
//                               zero-extend narrower pointers and truncate the
//                               result (leading zeros do not change either
//                               conversion)
package fifo_pkg;

  localparam int FIFO_P_SIZE = 3;
  localparam int FIFO_A_SIZE = FIFO_P_SIZE - 1;
  localparam int FIFO_MAX_W  = 8;

  function automatic logic [FIFO_MAX_W-1:0] bin2gray(input logic [FIFO_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [FIFO_MAX_W-1:0] gray2bin(input logic [FIFO_MAX_W-1:0] gray);
    logic [FIFO_MAX_W-1:0] bin;
    bin[FIFO_MAX_W-1] = gray[FIFO_MAX_W-1];
    for (int i = FIFO_MAX_W-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer entering the r_clk domain.
// Ports:
//   r_clk : destination clock
//   r_rst : asynchronous active-high reset, clears both stages to 0
//   d     : WIDTH-bit input from the foreign clock domain
//   q     : WIDTH-bit synchronised output, two r_clk edges behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;

  // stage p0: metastability capture; stage p1: settled output
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      sync_p0 <= '0;
      q       <= '0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO in the AHB2APB bridge.
// Tracks the read pointer, synchronises the write Gray pointer, detects empty
// and returns registered read data.
// Ports:
//   r_clk      : read clock
//   r_rst      : asynchronous active-high reset
//   FIFO_MEM   : F_DEPTH x D_SIZE entry array from the write-side memory
//   w_ptr_gray : write pointer (Gray, write clock domain)
//   r_inc      : read request, ignored while r_empty
//   r_data     : registered read data
//   r_valid    : one-cycle pulse when r_data was updated
//   r_empty    : registered empty flag
//   r_addr     : current read address
//   r_ptr_gray : registered read Gray pointer for the write-domain synchroniser
//   r_level    : registered occupancy, present only when FIFO_RD_LEVEL_EN is defined
// Build option: FIFO_RD_LEVEL_EN adds the r_level port and its logic.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int D_SIZE  = 16,
  parameter int F_DEPTH = 4,
  parameter int P_SIZE  = FIFO_P_SIZE
) (
  input  logic                          r_clk,
  input  logic                          r_rst,
  input  logic [F_DEPTH-1:0][D_SIZE-1:0] FIFO_MEM,
  input  logic [P_SIZE-1:0]             w_ptr_gray,
  input  logic                          r_inc,
  output logic [D_SIZE-1:0]             r_data,
  output logic                          r_valid,
  output logic                          r_empty,
  output logic [P_SIZE-2:0]             r_addr,
  output logic [P_SIZE-1:0]             r_ptr_gray
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [P_SIZE-1:0]             r_level
`endif
);

  localparam int A_SIZE = P_SIZE - 1;

  logic [P_SIZE-1:0] r_ptr_bin;
  logic [P_SIZE-1:0] r_ptr_bin_next;
  logic [P_SIZE-1:0] r_gray_next;
  logic [P_SIZE-1:0] rq2_wptr;
  logic              rd_en;

  sync_2ff #(.WIDTH(P_SIZE)) u_wptr_sync (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .d     (w_ptr_gray),
    .q     (rq2_wptr)
  );

  assign rd_en          = r_inc & ~r_empty;
  assign r_ptr_bin_next = r_ptr_bin + P_SIZE'(rd_en);
  assign r_gray_next    = P_SIZE'(bin2gray(FIFO_MAX_W'(r_ptr_bin_next)));
  assign r_addr         = r_ptr_bin[A_SIZE-1:0];

  // stage p0 -> p1: pointer, flags and read data all register on the same edge
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_ptr_bin  <= '0;
      r_ptr_gray <= '0;
      r_empty    <= 1'b1;
      r_valid    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_ptr_bin  <= r_ptr_bin_next;
      r_ptr_gray <= r_gray_next;
      // Compared against the already-synchronised pointer, so a write is
      // never seen early; empty can only be pessimistic.
      r_empty    <= (r_gray_next == rq2_wptr);
      r_valid    <= rd_en;
      if (rd_en) begin
        r_data <= FIFO_MEM[r_addr];
      end
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_level <= '0;
    end else begin
      r_level <= P_SIZE'(gray2bin(FIFO_MAX_W'(rq2_wptr))) - r_ptr_bin_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  localparam int D = 16;
  localparam int N = 4;
  localparam int P = 3;

  logic               r_clk = 1'b0;
  logic               r_rst = 1'b1;
  logic [N-1:0][D-1:0] mem = '0;
  logic [P-1:0]       w_ptr_gray = '0;
  logic               r_inc = 1'b0;
  logic [D-1:0]       r_data;
  logic               r_valid;
  logic               r_empty;
  logic [P-2:0]       r_addr;
  logic [P-1:0]       r_ptr_gray;
  logic [P-1:0]       r_level;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: unbounded write/read counts plus a queue of unread data.
  int           w_total = 0;
  int           r_total = 0;
  int           m_s1 = 0;
  int           m_rq2 = 0;
  bit           m_empty = 1;
  bit           m_valid = 0;
  logic [D-1:0] m_data = '0;
  int           m_level = 0;
  logic [D-1:0] q[$];

  fifo_read_ctrl #(.D_SIZE(D), .F_DEPTH(N), .P_SIZE(P)) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .FIFO_MEM   (mem),
    .w_ptr_gray (w_ptr_gray),
    .r_inc      (r_inc),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_empty    (r_empty),
    .r_addr     (r_addr),
    .r_ptr_gray (r_ptr_gray)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .r_level    (r_level)
`endif
  );

`ifndef FIFO_RD_LEVEL_EN
  assign r_level = '0;
`endif

  always #5 r_clk = ~r_clk;

  function automatic logic [P-1:0] gray(input int n);
    int b;
    b = n % 8;
    return P'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    w_total = 0; r_total = 0; m_s1 = 0; m_rq2 = 0;
    m_empty = 1; m_valid = 0; m_data = '0; m_level = 0;
    q.delete();
    w_ptr_gray = '0;
  endtask

  // Write side: place data in the next slot and publish the new pointer.
  task automatic push(input logic [D-1:0] v);
    mem[w_total % N] = v;
    w_total++;
    w_ptr_gray = gray(w_total);
    q.push_back(v);
  endtask

  // One clock: advance the model on the rising edge, return at the falling edge.
  task automatic tick();
    int  rq2_pre;
    bit  rd;
    @(posedge r_clk);
    if (r_rst) begin
      m_s1 = 0; m_rq2 = 0; m_empty = 1; m_valid = 0; m_data = '0; m_level = 0;
      r_total = 0;
    end else begin
      rq2_pre = m_rq2;
      rd = r_inc && !m_empty;
      m_rq2 = m_s1;
      m_s1 = w_total;
      m_valid = rd;
      if (rd) begin
        m_data = q.pop_front();
        r_total++;
      end
      m_empty = (r_total == rq2_pre);
      m_level = (rq2_pre - r_total) & 7;
    end
    @(negedge r_clk);
  endtask

  task automatic test_reset();
    r_rst = 1'b1;
    model_reset();
    repeat (3) tick();
    vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b want=1", r_empty); end
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", r_valid); end
    vectors++; if (r_ptr_gray !== 3'b000) begin miscompares++; $display("FAIL reset_gray got=%b want=000", r_ptr_gray); end
    vectors++; if (r_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got=%h want=0000", r_data); end
    vectors++; if (r_addr !== 2'd0) begin miscompares++; $display("FAIL reset_addr got=%0d want=0", r_addr); end
    r_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    push(16'hA5A5);
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (r_empty !== (i < 3)) begin
        miscompares++; $display("FAIL single_empty_edge%0d got=%b want=%b", i, r_empty, (i < 3));
      end
    end
    r_inc = 1'b1;
    tick();
    r_inc = 1'b0;
    vectors++; if (r_data !== 16'hA5A5) begin miscompares++; $display("FAIL single_data got=%h want=a5a5", r_data); end
    vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got=%b want=1", r_valid); end
    vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("FAIL single_empty_after got=%b want=1", r_empty); end
    vectors++; if (r_ptr_gray !== 3'b001) begin miscompares++; $display("FAIL single_gray got=%b want=001", r_ptr_gray); end
    tick();
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_pulse got=%b want=0", r_valid); end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 4; k++) push(16'(k));
    repeat (3) tick();
    r_inc = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (r_valid !== (c < 4)) begin
        miscompares++; $display("FAIL drain_valid c=%0d got=%b want=%b", c, r_valid, (c < 4));
      end
      if (c < 4) begin
        vectors++;
        if (r_data !== 16'(c + 1)) begin
          miscompares++; $display("FAIL drain_data c=%0d got=%h want=%h", c, r_data, 16'(c + 1));
        end
      end
    end
    r_inc = 1'b0;
    vectors++; if (r_empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got=%b want=1", r_empty); end
    vectors++; if (r_ptr_gray !== gray(5)) begin miscompares++; $display("FAIL drain_gray got=%b want=%b", r_ptr_gray, gray(5)); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int idx = 0;
    int start_r = r_total;
    while (sent < 10) begin
      for (int j = 0; j < 3 && sent < 10; j++) begin
        push(16'h1000 + 16'(sent));
        sent++;
      end
      repeat (3) tick();
      r_inc = 1'b1;
      for (int c = 0; c < 5; c++) begin
        if (!r_empty) begin
          vectors++;
          if (r_addr !== 2'((start_r + idx) % N)) begin
            miscompares++; $display("FAIL wrap_addr idx=%0d got=%0d want=%0d", idx, r_addr, (start_r + idx) % N);
          end
        end
        tick();
        if (r_valid) begin
          vectors++;
          if (r_data !== 16'h1000 + 16'(idx)) begin
            miscompares++; $display("FAIL wrap_data idx=%0d got=%h want=%h", idx, r_data, 16'h1000 + 16'(idx));
          end
          vectors++;
          if (r_ptr_gray !== gray(r_total)) begin
            miscompares++; $display("FAIL wrap_gray idx=%0d got=%b want=%b", idx, r_ptr_gray, gray(r_total));
          end
          idx++;
        end
      end
      r_inc = 1'b0;
    end
    vectors++; if (idx !== 10) begin miscompares++; $display("FAIL wrap_count got=%0d want=10", idx); end
  endtask

  task automatic test_empty_read();
    logic [P-1:0] g0;
    g0 = gray(r_total);
    r_inc = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (r_valid !== 1'b0 || r_empty !== 1'b1) begin
        miscompares++; $display("FAIL empty_read_flags c=%0d valid=%b empty=%b want valid=0 empty=1", c, r_valid, r_empty);
      end
      vectors++;
      if (r_ptr_gray !== g0 || r_data !== m_data) begin
        miscompares++; $display("FAIL empty_read_hold c=%0d gray=%b data=%h want gray=%b data=%h", c, r_ptr_gray, r_data, g0, m_data);
      end
    end
    r_inc = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ((w_total - r_total) < N && ($urandom_range(0, 2) != 0)) push(16'($urandom));
      r_inc = ($urandom_range(0, 1) == 1);
      tick();
      vectors++;
      if (r_valid !== m_valid || r_empty !== m_empty) begin
        miscompares++; $display("FAIL rand_flags c=%0d valid=%b empty=%b want valid=%b empty=%b", c, r_valid, r_empty, m_valid, m_empty);
      end
      vectors++;
      if (r_data !== m_data || r_ptr_gray !== gray(r_total) || r_addr !== 2'(r_total % N)) begin
        miscompares++; $display("FAIL rand_data c=%0d data=%h gray=%b addr=%0d want data=%h gray=%b addr=%0d",
                                c, r_data, r_ptr_gray, r_addr, m_data, gray(r_total), r_total % N);
      end
`ifdef FIFO_RD_LEVEL_EN
      vectors++;
      if (r_level !== P'(m_level)) begin
        miscompares++; $display("FAIL rand_level c=%0d got=%0d want=%0d", c, r_level, m_level);
      end
`endif
    end
    r_inc = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Drain leftovers so the drain below starts from a known occupancy.
    r_inc = 1'b1;
    repeat (8) tick();
    r_inc = 1'b0;
    for (int k = 0; k < 4; k++) push(16'hC000 + 16'(k));
    repeat (3) tick();
`ifdef FIFO_RD_LEVEL_EN
    vectors++; if (r_level !== 3'd4) begin miscompares++; $display("FAIL mid_level_full got=%0d want=4", r_level); end
`endif
    r_inc = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (r_data !== 16'hC000 + 16'(c)) begin
        miscompares++; $display("FAIL mid_data c=%0d got=%h want=%h", c, r_data, 16'hC000 + 16'(c));
      end
`ifdef FIFO_RD_LEVEL_EN
      vectors++;
      if (r_level !== 3'(3 - c)) begin miscompares++; $display("FAIL mid_level c=%0d got=%0d want=%0d", c, r_level, 3 - c); end
`endif
    end
    r_rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (r_empty !== 1'b1 || r_valid !== 1'b0 || r_data !== 16'h0 || r_ptr_gray !== 3'b0 || r_addr !== 2'd0) begin
      miscompares++; $display("FAIL mid_async_reset empty=%b valid=%b data=%h gray=%b addr=%0d want 1 0 0000 000 0",
                              r_empty, r_valid, r_data, r_ptr_gray, r_addr);
    end
`ifdef FIFO_RD_LEVEL_EN
    vectors++; if (r_level !== 3'd0) begin miscompares++; $display("FAIL mid_level_reset got=%0d want=0", r_level); end
`endif
    r_inc = 1'b0;
    tick();
    r_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (r_empty !== 1'b1) begin miscompares++; $display("FAIL mid_post_empty c=%0d got=%b want=1", c, r_empty); end
    end
    push(16'h5A5A);
    repeat (3) tick();
    vectors++; if (r_empty !== 1'b0) begin miscompares++; $display("FAIL mid_refill_empty got=%b want=0", r_empty); end
    r_inc = 1'b1;
    tick();
    r_inc = 1'b0;
    vectors++; if (r_data !== 16'h5A5A || r_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_refill_data got=%h valid=%b want=5a5a valid=1", r_data, r_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drain();
    test_wrap();
    test_empty_read();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
